// File: rtl/btn_conditioner_pkg.sv
// Shared definitions for the push-button conditioner: FSM state encoding
// and a helper that maps a state to the committed output level.
package btn_conditioner_pkg;

  typedef enum logic [1:0] {
    S_LOW      = 2'd0,
    S_RISE_CHK = 2'd1,
    S_HIGH     = 2'd2,
    S_FALL_CHK = 2'd3
  } state_t;

  // While a fall is being qualified the committed level is still high.
  function automatic logic level_of(input state_t s);
    return (s == S_HIGH) || (s == S_FALL_CHK);
  endfunction

endpackage

// File: rtl/btn_conditioner_sync.sv
// Plain flip-flop synchronizer for the asynchronous button input.
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic CLK,
  input  logic nRST,
  input  logic D,
  output logic Q
);

  logic [STAGES-1:0] stage_q;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      stage_q <= '0;
    end else begin
      stage_q <= {stage_q[STAGES-2:0], D};
    end
  end

  assign Q = stage_q[STAGES-1];

endmodule

// File: rtl/btn_conditioner.sv
// Debounces a bouncing push-button level and emits one-cycle pulses on each
// committed rising and falling change.
//
// state      | meaning
// S_LOW      | committed low, waiting for synchronized input to go high
// S_RISE_CHK | input high, counting agreeing samples before committing high
// S_HIGH     | committed high, waiting for synchronized input to go low
// S_FALL_CHK | input low, counting agreeing samples before committing low
module btn_conditioner
  import btn_conditioner_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 4,
  parameter int CNT_W       = 8
) (
  input  logic CLK,
  input  logic nRST,
  input  logic RAW_IN,
  output logic DB_LEVEL,
  output logic RISE_PULSE,
  output logic FALL_PULSE
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             x_s;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             db_q, db_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  sync_chain #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .CLK (CLK),
    .nRST(nRST),
    .D   (RAW_IN),
    .Q   (x_s)
  );

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= S_LOW;
      cnt_q   <= '0;
      db_q    <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      db_q    <= db_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // cnt counts agreeing samples already seen; commit happens on the sample
  // that finds cnt at DB_CYCLES-1, so it never wraps.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_LOW: begin
        if (x_s) begin
          state_d = S_RISE_CHK;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = '0;
        end
      end
      S_RISE_CHK: begin
        if (!x_s) begin
          state_d = S_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_HIGH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_HIGH: begin
        if (!x_s) begin
          state_d = S_FALL_CHK;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = '0;
        end
      end
      S_FALL_CHK: begin
        if (x_s) begin
          state_d = S_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_LOW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = S_LOW;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so the registered copies line up
  // with the state register.
  always_comb begin
    db_d   = level_of(state_d);
    rise_d = (state_q == S_RISE_CHK) && (state_d == S_HIGH);
    fall_d = (state_q == S_FALL_CHK) && (state_d == S_LOW);
  end

  assign DB_LEVEL   = db_q;
  assign RISE_PULSE = rise_q;
  assign FALL_PULSE = fall_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Self-checking bench for btn_conditioner: table of per-cycle vectors with a
// scoreboard queue, plus hand sequences for reset-in-check and a short config.
`timescale 1ns/1ps
module tb_btn_conditioner;
  import btn_conditioner_pkg::*;

  logic clk = 1'b0;
  logic nrst, raw, db, rise, fall;
  logic nrst2, raw2, db2, rise2, fall2;

  always #5 clk = ~clk;

  btn_conditioner dut (
    .CLK(clk), .nRST(nrst), .RAW_IN(raw),
    .DB_LEVEL(db), .RISE_PULSE(rise), .FALL_PULSE(fall)
  );

  btn_conditioner #(.SYNC_STAGES(3), .DB_CYCLES(2), .CNT_W(8)) dut2 (
    .CLK(clk), .nRST(nrst2), .RAW_IN(raw2),
    .DB_LEVEL(db2), .RISE_PULSE(rise2), .FALL_PULSE(fall2)
  );

  typedef struct {
    logic n;
    logic r;
    logic d;
    logic ri;
    logic f;
  } vec_t;

  typedef struct {
    int   idx;
    logic d;
    logic ri;
    logic f;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;
  int   vec_idx = 0;

  task automatic check(input string name, input int idx, input logic act, input logic expv);
    checks++;
    if (act === expv) passes++;
    else $display("FAIL %s @step %0d: got %b expected %b", name, idx, act, expv);
  endtask

  task automatic checki(input string name, input int act, input int expv);
    checks++;
    if (act == expv) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, expv);
  endtask

  task automatic add(input logic n, input logic r, input logic d, input logic ri, input logic f);
    vec_t v;
    v.n = n; v.r = r; v.d = d; v.ri = ri; v.f = f;
    vecs.push_back(v);
  endtask

  // Drive one cycle, push the expectation, compare after the edge.
  task automatic step(input logic n, input logic r, input logic d, input logic ri, input logic f);
    exp_t e;
    e.idx = vec_idx; e.d = d; e.ri = ri; e.f = f;
    nrst = n;
    raw  = r;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("db_level",   e.idx, db,   e.d);
    check("rise_pulse", e.idx, rise, e.ri);
    check("fall_pulse", e.idx, fall, e.f);
    check("excl",       e.idx, rise & fall, 1'b0);
    vec_idx++;
  endtask

  initial begin
    int found;
    logic [11:0] bounce;

    nrst = 1'b0; raw = 1'b0; nrst2 = 1'b0; raw2 = 1'b0;

    // reset
    add(0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0);
    // steady press: commit at edge 5
    for (int i = 0; i < 8; i++) add(1, 1, (i >= 5), (i == 5), 0);
    // 3-cycle low glitch from S_HIGH is rejected
    for (int i = 0; i < 8; i++) add(1, (i >= 3), 1, 0, 0);
    // steady release: fall pulse at edge 5
    for (int i = 0; i < 8; i++) add(1, 0, (i < 5), 0, (i == 5));
    // bounce 1,0,1,0,1 then steady 1: single rise at step 9
    bounce = 12'b1111_1111_0101;
    for (int i = 0; i < 12; i++) add(1, bounce[i], (i >= 9), (i == 9), 0);
    // release back to S_LOW
    for (int i = 0; i < 8; i++) add(1, 0, (i < 5), 0, (i == 5));

    for (int i = 0; i < vecs.size(); i++) step(vecs[i].n, vecs[i].r, vecs[i].d, vecs[i].ri, vecs[i].f);

    // Reset while S_RISE_CHK holds cnt=3
    for (int i = 0; i < 5; i++) step(1, 1, 0, 0, 0);
    check("pre_rst_state", vec_idx, dut.state_q == S_RISE_CHK, 1'b1);
    checki("pre_rst_cnt", int'(dut.cnt_q), 3);
    step(0, 1, 0, 0, 0);
    check("rst_state", vec_idx, dut.state_q == S_LOW, 1'b1);
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 7; i++) step(1, 1, (i >= 5), (i == 5), 0);

    // Short config: SYNC_STAGES=3, DB_CYCLES=2 -> rise at edge 4
    nrst2 = 1'b0;
    raw2  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("cfg2_rst_db", 0, db2, 1'b0);
    nrst2 = 1'b1;
    raw2  = 1'b1;
    found = -1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (rise2) begin
        found = k;
        break;
      end
    end
    checki("cfg2_rise_edge", found, 4);
    check("cfg2_db", 0, db2, 1'b1);
    check("cfg2_fall", 0, fall2, 1'b0);
    @(posedge clk);
    #1;
    check("cfg2_rise_once", 1, rise2, 1'b0);
    check("cfg2_db_hold", 1, db2, 1'b1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
